// File: rtl/counter_ctrl_arb_pkg.sv
// ---------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared types and constants for the counter command controller/arbiter.
//   cmd_e   : command requested by a requester (clear/set/load/nop)
//   state_e : controller FSM states
//   CNT_W   : width of the shared counter value
//   idWidth : width of a requester index for a given requester count
// ---------------------------------------------------------------------------
package counter_ctrl_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    CMD_CLR  = 2'd0,
    CMD_SET  = 2'd1,
    CMD_LOAD = 2'd2,
    CMD_NOP  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // A single requester still needs a one-bit index field.
  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_ctrl_arb_if.sv
// ---------------------------------------------------------------------------
// counter_ctrl_arb_if
// Bundles the requester handshake and the counter control pins.
//   req/cmd/hold : per-requester request level, command and hold count
//   gnt          : one-hot accept pulse back to the requesters
//   count        : observed counter value
//   cnt_*        : one-cycle control pulses to the counter
//   busy/done/done_id/result : controller status and completion data
// Modports: master = requester/counter side, slave = controller side.
// ---------------------------------------------------------------------------
interface counter_ctrl_arb_if
  import counter_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int HOLD_W = 4
);

  localparam int IDW = idWidth(NREQ);

  logic [NREQ-1:0]        req;
  logic [2*NREQ-1:0]      cmd;
  logic [HOLD_W*NREQ-1:0] hold;
  logic [NREQ-1:0]        gnt;
  logic [CNT_W-1:0]       count;
  logic                   cnt_reset;
  logic                   cnt_set;
  logic                   cnt_load;
  logic                   busy;
  logic                   done;
  logic [IDW-1:0]         done_id;
  logic [CNT_W-1:0]       result;

  modport master (
    output req, cmd, hold, count,
    input  gnt, cnt_reset, cnt_set, cnt_load, busy, done, done_id, result
  );

  modport slave (
    input  req, cmd, hold, count,
    output gnt, cnt_reset, cnt_set, cnt_load, busy, done, done_id, result
  );

endinterface

// File: rtl/counter_ctrl_arb_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker.
//   req    : request levels
//   last   : index of the most recently served requester
//   gnt    : one-hot winner (all zero when nothing is requested)
//   winner : index of the winner (zero when nothing is requested)
// ---------------------------------------------------------------------------
module rr_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = idWidth(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  winner
);

  logic found;
  int   idx;

  // Walk the requesters starting just after the last one served and
  // wrapping around, so the previous owner is considered last. The
  // modulo also keeps a stale out-of-range index from selecting nothing.
  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/counter_ctrl_arb.sv
// ---------------------------------------------------------------------------
// counter_ctrl_arb
// Grants counter commands to one requester at a time (round-robin), issues
// the matching one-cycle control pulse, holds ownership for the requested
// number of cycles and returns the counter value sampled at completion.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of counter_ctrl_arb_if (requests, counter pins, status)
// ---------------------------------------------------------------------------
module counter_ctrl_arb
  import counter_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  counter_ctrl_arb_if.slave bus
);

  localparam int IDW = idWidth(NREQ);

  state_e            state_q, state_d;
  cmd_e              cmd_q;
  logic [HOLD_W-1:0] holdVal_q;
  logic [HOLD_W-1:0] holdCnt_q;
  logic [IDW-1:0]    owner_q;
  logic [IDW-1:0]    last_q;
  logic              done_q;
  logic [IDW-1:0]    doneId_q;
  logic [CNT_W-1:0]  result_q;

  logic [NREQ-1:0]   arbGnt;
  logic [IDW-1:0]    winner;
  int                sel;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) uArb (
    .req    (bus.req),
    .last   (last_q),
    .gnt    (arbGnt),
    .winner (winner)
  );

  assign sel = int'(winner);

  // Next-state logic. A zero hold skips HOLD entirely; otherwise HOLD is
  // left when the down-counter reaches one, giving exactly 'hold' cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.req) state_d = ISSUE;
      ISSUE:   state_d = (holdVal_q != '0) ? HOLD : DONE;
      HOLD:    if (holdCnt_q == HOLD_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latches and completion registers. The command, hold count and
  // owner are captured at grant so later input changes cannot disturb the
  // command in flight. done/done_id are registered from the next state so
  // they line up exactly with the DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= CMD_NOP;
      holdVal_q <= '0;
      holdCnt_q <= '0;
      owner_q   <= '0;
      last_q    <= IDW'(NREQ - 1);
      done_q    <= 1'b0;
      doneId_q  <= '0;
      result_q  <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= (state_d == DONE);
      doneId_q <= (state_d == DONE) ? owner_q : '0;
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            cmd_q     <= cmd_e'(bus.cmd[2*sel +: 2]);
            holdVal_q <= bus.hold[HOLD_W*sel +: HOLD_W];
            owner_q   <= winner;
          end
        end
        ISSUE:   holdCnt_q <= holdVal_q;
        HOLD:    holdCnt_q <= holdCnt_q - HOLD_W'(1);
        DONE: begin
          result_q <= bus.count;
          last_q   <= owner_q;
        end
        default: ;
      endcase
    end
  end

  // Grant and control pulses are decoded from the state register only, so
  // the counter value never feeds back combinationally into its own pins.
  assign bus.gnt       = (state_q == IDLE) ? arbGnt : '0;
  assign bus.cnt_reset = (state_q == ISSUE) && (cmd_q == CMD_CLR);
  assign bus.cnt_set   = (state_q == ISSUE) && (cmd_q == CMD_SET);
  assign bus.cnt_load  = (state_q == ISSUE) && (cmd_q == CMD_LOAD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.done_id   = doneId_q;
  assign bus.result    = result_q;

endmodule

// File: doc/counter_ctrl_arb.md
# counter_ctrl_arb

Command controller and arbiter for the shared 3-bit counter (`counter_3bit`).
- Accepts counter commands from `NREQ` requesters and grants one at a time, round-robin.
- Issues the selected one-cycle control pulse (`reset`/`set`/`load`), then holds ownership for a programmable number of cycles.
- Returns the counter value sampled at the end of the hold to the owning requester.
- Sits between requester logic and the counter's control pins. The top level ORs `cnt_reset` with the system reset before it reaches the counter.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, range 2..8.
- `HOLD_W`, default 4: width of each requester's hold-count field.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in NREQ: per-requester request level; held until granted.
- `cmd` in 2*NREQ: per-requester command, slice i = bits [2i+1:2i].
- `hold` in HOLD_W*NREQ: per-requester hold cycles after the pulse.
- `gnt` out NREQ: one-hot, one-cycle accept pulse.
- `count` in 3: counter output, observed.
- `cnt_reset`, `cnt_set`, `cnt_load` out 1 each: control pulses to the counter.
- `busy` out 1: FSM is not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `done_id` out clog2(NREQ): owner of the completing command.
- `result` out 3: `count` sampled in the DONE cycle; holds until the next `done`.

## Operation
- Command encoding:
  - 0 `CMD_CLR` drives `cnt_reset`.
  - 1 `CMD_SET` drives `cnt_set`.
  - 2 `CMD_LOAD` drives `cnt_load`.
  - 3 `CMD_NOP` drives no pulse but still holds and samples.
- FSM states: IDLE, ISSUE, HOLD, DONE.
- IDLE:
  - If any `req` is set, choose a winner round-robin, searching from `last+1` upward with wrap.
  - Assert `gnt[winner]` combinationally in the same cycle.
  - Latch `cmd`, `hold` and the owner; go to ISSUE.
  - If no `req` is set, stay in IDLE with no outputs asserted.
- ISSUE:
  - Assert exactly one control pulse per the latched command.
  - Load `hold_cnt` with the latched hold value.
  - Go to HOLD if the hold value is non-zero, otherwise to DONE.
- HOLD:
  - All control pulses are low; the counter runs on its own.
  - Decrement `hold_cnt` each cycle. Go to DONE on the cycle `hold_cnt` equals 1, which gives exactly `hold` HOLD cycles.
- DONE:
  - Pulse `done`; drive `done_id` with the owner.
  - Register `result <= count`; update `last <= owner`.
  - Go to IDLE.
- Requester rules:
  - A requester must drop `req` in the cycle after its `gnt`.
  - A `req` still high in the next IDLE is treated as a new request.
- Changes to `cmd`/`hold` after `gnt` have no effect; both are latched at grant.
- At most one of `cnt_reset`/`cnt_set`/`cnt_load` is high in any cycle, and only in ISSUE.
- `gnt` is asserted only in IDLE.

## Timing
- A request granted in cycle T produces:
  - the control pulse in T+1;
  - `done` in T+2+hold;
  - IDLE again at T+3+hold.
- Earliest next grant is T+3+hold, so back-to-back throughput is one command per hold+3 cycles.
- `result`, `done_id` and `done` are registered. `gnt` and the `cnt_*` pulses are decoded from the state register and contain no combinational path from `count`.
- Reset values:
  - state IDLE; all outputs 0; `result` 0; `done_id` 0.
  - `last` = NREQ-1, so requester 0 wins first.
- Reset asserted mid-command:
  - Immediate return to IDLE.
  - Any in-flight pulse is cut; no `done` is issued for the aborted command.
  - The requester must re-request.
- Simultaneous requests are resolved by round-robin only; no requester can be starved. With all requesters held high, each gets exactly one grant per NREQ grants.

## Structure
- Package `counter_ctrl_pkg` holds:
  - `cmd_e` (CMD_CLR, CMD_SET, CMD_LOAD, CMD_NOP);
  - `state_e` (IDLE, ISSUE, HOLD, DONE);
  - the width constant `CNT_W = 3`.
- Sub-module `rr_arbiter`, parameterised by NREQ:
  - inputs `req` and `last`; outputs one-hot `gnt` and index `winner`;
  - purely combinational, instantiated once.
- The top module contains the FSM, the command/hold/owner latches and the result register.

## Test plan
- Reset release, no requests: all outputs 0 and `busy` = 0 for 20 cycles.
- Single request: `req[0]`, `cmd` = SET, `hold` = 3, granted at T. Require `cnt_set` high only at T+1, `done` at T+5, `done_id` = 0, `result` equal to the counter value at T+5.
- Concurrent requests: `req` = 2'b11 held continuously, `hold` = 0. Grants alternate 0,1,0,1, spaced 3 cycles apart.
- Zero hold with NOP: `cmd` = NOP, `hold` = 0. No `cnt_*` pulse; `done` at T+2.
- Reset mid-HOLD: `hold` = 10, assert `reset` at T+4. Outputs clear immediately; no `done`; after release, `req[1]` wins before `req[0]` only if `req[0]` is low.
- Command change after grant: switch `cmd` from LOAD to CLR at T+1. `cnt_load` pulses at T+1; `cnt_reset` never asserts.
